// File: rtl/i2c_bus_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared constants and arming FSM type for the I2C bus conditioner.
// Rev     : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_SYNC_STAGES_DEF   = 2;
    localparam int I2C_FILTER_CYCLES_DEF = 5;
    localparam int I2C_CNT_W             = 4;
    localparam int I2C_SETTLE_W          = 5;

    typedef enum logic {
        ARMING = 1'b0,
        ARMED  = 1'b1
    } i2c_arm_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_conditioner_line_filter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_line_filter
// Brief   : Per-line synchronizer and stability filter; rise/fall/spike are
//           strobes describing what the filtered level does on the next edge.
// Rev     : 1.0 - initial release
// ============================================================================
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
    input  logic clk100,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic spike
);

    localparam logic [I2C_CNT_W-1:0] c_FILTER_MAX = 4'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [I2C_CNT_W-1:0]   r_cnt;
    logic                   r_level;

    logic w_synced;
    logic w_differ;
    logic w_accept;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_synced != r_level);
    assign w_accept = w_differ && (r_cnt == c_FILTER_MAX);

    assign level = r_level;
    assign rise  = w_accept && w_synced;
    assign fall  = w_accept && !w_synced;
    // A disagreement that ends before acceptance leaves a nonzero count behind.
    assign spike = !w_differ && (r_cnt != '0);

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            r_sync  <= '1;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], line_in};
            if (w_accept) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : i2c_bus_conditioner
// Brief   : Filtered SCL/SDA levels with registered edge, START/STOP, busy and
//           glitch-count outputs, gated by a post-reset arming FSM.
// Rev     : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
    input  logic       clk100,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       bus_busy,
    output logic [7:0] glitch_count
);

    localparam logic [I2C_SETTLE_W-1:0] c_SETTLE_LOAD = 5'(SYNC_STAGES + FILTER_CYCLES);

    logic w_scl_level, w_scl_rise, w_scl_fall, w_scl_spike;
    logic w_sda_level, w_sda_rise, w_sda_fall, w_sda_spike;
    logic w_scl_steady_hi;
    logic w_start_det;
    logic w_stop_det;
    logic [8:0] w_glitch_sum;

    i2c_arm_state_t          r_state;
    logic [I2C_SETTLE_W-1:0] r_settle;
    logic                    r_scl_rise;
    logic                    r_scl_fall;
    logic                    r_start;
    logic                    r_stop;
    logic                    r_busy;
    logic [7:0]              r_glitch;

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl_filter (
        .clk100  (clk100),
        .reset_n (reset_n),
        .line_in (scl_in),
        .level   (w_scl_level),
        .rise    (w_scl_rise),
        .fall    (w_scl_fall),
        .spike   (w_scl_spike)
    );

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda_filter (
        .clk100  (clk100),
        .reset_n (reset_n),
        .line_in (sda_in),
        .level   (w_sda_level),
        .rise    (w_sda_rise),
        .fall    (w_sda_fall),
        .spike   (w_sda_spike)
    );

    // SCL high now and not changing on this edge means high before and after it.
    assign w_scl_steady_hi = w_scl_level && !w_scl_rise && !w_scl_fall;
    assign w_start_det     = w_scl_steady_hi && w_sda_fall;
    assign w_stop_det      = w_scl_steady_hi && w_sda_rise;
    assign w_glitch_sum    = {1'b0, r_glitch} + {8'd0, w_scl_spike} + {8'd0, w_sda_spike};

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            r_state  <= ARMING;
            r_settle <= c_SETTLE_LOAD;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            case (r_state)
                ARMING: begin
                    if (r_settle == '0) begin
                        r_state <= ARMED;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ARMED: begin
                    if (w_start_det) begin
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_stop_det) begin
                        r_stop <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= ARMING;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n) begin
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_glitch   <= '0;
        end else begin
            r_scl_rise <= w_scl_rise;
            r_scl_fall <= w_scl_fall;
            r_glitch   <= w_glitch_sum[8] ? 8'hFF : w_glitch_sum[7:0];
        end
    end

    assign scl_o        = w_scl_level;
    assign sda_o        = w_sda_level;
    assign scl_rise     = r_scl_rise;
    assign scl_fall     = r_scl_fall;
    assign start_pulse  = r_start;
    assign stop_pulse   = r_stop;
    assign bus_busy     = r_busy;
    assign glitch_count = r_glitch;

endmodule
`default_nettype wire

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Front-end stage for the I2C target logic: takes raw SCL/SDA pad levels and produces clean, synchronized, glitch-filtered line levels. It also produces single-cycle edge, START and STOP pulses. It sits between the `ck_scl`/`ck_sda` pins and the I2C address/ACK logic, which consumes `scl_o`, `sda_o` and the event pulses instead of sampling pins directly. It runs entirely in the `clk100` domain.

## Interface
Parameters:
- `SYNC_STAGES`, default 2 — flip-flops in each input synchronizer chain; legal range 2..4.
- `FILTER_CYCLES`, default 5 — consecutive stable cycles needed to accept a new level (50 ns at 100 MHz); legal range 1..15.

Ports (one clock; reset is synchronous and active-low):
- `clk100` — input, 1 bit — system clock, 100 MHz.
- `reset_n` — input, 1 bit — synchronous, active-low reset.
- `scl_in` — input, 1 bit — raw SCL pad level, asynchronous.
- `sda_in` — input, 1 bit — raw SDA pad level, asynchronous.
- `scl_o` — output, 1 bit — filtered SCL level.
- `sda_o` — output, 1 bit — filtered SDA level.
- `scl_rise` — output, 1 bit — 1-cycle pulse when `scl_o` goes 0→1.
- `scl_fall` — output, 1 bit — 1-cycle pulse when `scl_o` goes 1→0.
- `start_pulse` — output, 1 bit — 1-cycle pulse on START or repeated START.
- `stop_pulse` — output, 1 bit — 1-cycle pulse on STOP.
- `bus_busy` — output, 1 bit — high from START until STOP.
- `glitch_count` — output, 8 bits — saturating count of rejected spikes on both lines combined.

## Operation
- **Synchronizer.** Each line goes through its own `SYNC_STAGES`-deep chain.
- **Filter.** Each line has its own `FILTER_CYCLES`-wide counter (4 bits).
  - When the synchronized level differs from the filtered level, the counter increments.
  - When the counter reaches `FILTER_CYCLES`, the filtered level takes the new value and the counter clears.
  - When the synchronized level equals the filtered level, the counter clears.
  - A clear from a nonzero count is a rejected spike and increments `glitch_count`.
  - `glitch_count` saturates at 255. A rejected spike on both lines in the same cycle adds 2, still saturating.
- **SCL edges.** `scl_rise` and `scl_fall` are decoded by comparing the new and previous filtered SCL values.
- **START.** `start_pulse` fires when `sda_o` goes 1→0 while `scl_o` is 1 both before and after that clock edge.
- **STOP.** `stop_pulse` fires under the same condition with `sda_o` going 0→1.
- **Simultaneous SCL and SDA change** (same cycle): this is not a START or STOP. No `start_pulse` or `stop_pulse`; `scl_rise`/`scl_fall` still fire.
- **`bus_busy`.** Set on START, cleared on STOP. A repeated START while busy pulses `start_pulse` and leaves `bus_busy` at 1.
- **Arming FSM.** States are `ARMING` and `ARMED`.
  - After reset the FSM is in `ARMING` and loads a settle counter with `SYNC_STAGES + FILTER_CYCLES`.
  - In `ARMING`, `start_pulse` and `stop_pulse` are suppressed; filtered levels and SCL edge pulses are still produced. This prevents a false START when SDA is held low through reset.
  - When the settle counter reaches 0, the FSM moves to `ARMED` and stays there until the next reset.

## Timing
- **Reset values** (on any edge with `reset_n`=0): all synchronizer stages 1; `scl_o`=1, `sda_o`=1; filter counters 0; all pulse outputs 0; `bus_busy`=0; `glitch_count`=0; FSM in `ARMING`.
- **Reset mid-transfer** forces all of the above immediately, on the same edge. `bus_busy` drops even with no STOP.
- **Latency.** A raw level change held stable before edge 0 appears on `scl_o`/`sda_o` after edge `SYNC_STAGES + FILTER_CYCLES`. With default parameters this is edge 7.
- **Pulse alignment.** All pulses are registered. Each is high for exactly the first cycle in which the corresponding filtered output shows its new level.
- **`bus_busy` timing.** Changes on the same edge as `start_pulse`/`stop_pulse`, so it is visible one cycle after the pulse is sampled.
- **Spike rejection.** A raw pulse stable for up to `FILTER_CYCLES`-1 synchronized cycles never reaches `scl_o`/`sda_o`.
- **Arming.** The first START that can be reported lands on edge `SYNC_STAGES + FILTER_CYCLES` after reset release, or later.

## Structure
- **`i2c_pkg`** holds:
  - constants `I2C_SYNC_STAGES_DEF`=2 and `I2C_FILTER_CYCLES_DEF`=5;
  - the arming FSM typedef `i2c_arm_state_t` (`ARMING`, `ARMED`).
- **`i2c_line_filter`** is the natural sub-module:
  - contents: synchronizer, filter counter, filtered level register;
  - outputs: `level`, `rise`, `fall`, `spike` (1-cycle pulse);
  - instantiated twice, once per line.
- **Top level** contains the START/STOP decode, `bus_busy`, the `glitch_count` saturating adder, and the arming FSM.

## Test plan
- **Reset:** hold `reset_n`=0 with `sda_in`=0, `scl_in`=1; release → `sda_o` falls at edge 7, `start_pulse` never asserts, `bus_busy`=0.
- **Spike rejection:** 3-cycle low pulse on `scl_in` (defaults) → `scl_o` stays 1, no `scl_fall`, `glitch_count`=1. Repeat 300 times → `glitch_count`=255.
- **START/STOP:** armed, `scl_in`=1, drop `sda_in` → `start_pulse` for one cycle 7 edges later and `bus_busy`=1. Raise `sda_in` → `stop_pulse` for one cycle and `bus_busy`=0.
- **Simultaneous change:** drop `scl_in` and `sda_in` in the same cycle → `scl_fall`=1, `start_pulse`=0, `bus_busy` unchanged.
- **Repeated START:** during a transfer with `scl`=1 and `sda` 1→0 → `start_pulse`=1, `bus_busy` stays 1. Then assert reset mid-byte → all outputs return to their reset values on the same edge.
- **Byte traffic:** 0x42 write address at 100 kHz → exactly 9 `scl_rise` pulses between `start_pulse` and the next `scl_fall` after the ACK clock; `sda_o` matches each bit at its `scl_rise`.
